// File: rtl/shared_key_schedule_engine.sv
// Two-share masked key schedule: produces round keys RK0..RK(NROUNDS) as share pairs, never recombining shares.
// Optional build macro KEY_SCHED_REMASK_EN adds rand_in, which is XORed into both shares after every round.
module shared_key_schedule_engine #(
    parameter int KEY_W    = 128,
    parameter int NROUNDS  = 16,
    parameter int SBOX_LAT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             ready,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_in0,
    input  logic [KEY_W-1:0] key_in1,
`ifdef KEY_SCHED_REMASK_EN
    input  logic [KEY_W-1:0] rand_in,
`endif
    output logic [127:0]     rk_out0,
    output logic [127:0]     rk_out1,
    output logic [4:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             done
);

    localparam int HALF_W = KEY_W / 2;
    localparam int NIB = HALF_W / 4;
    localparam logic [4:0] LAST_IDX = 5'(NROUNDS);

    if (KEY_W != 128 && KEY_W != 256) begin : g_bad_key_w
        $error("shared_key_schedule_engine: KEY_W must be 128 or 256");
    end
    if (SBOX_LAT < 1 || SBOX_LAT > 3) begin : g_bad_sbox_lat
        $error("shared_key_schedule_engine: SBOX_LAT must be 1..3");
    end
    if (NROUNDS < 1 || NROUNDS > 31) begin : g_bad_nrounds
        $error("shared_key_schedule_engine: NROUNDS must fit a 5-bit index");
    end

    typedef enum logic [1:0] {IDLE, LOAD, STEP, PRESENT} state_t;

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int n);
        return (x << n) | (x >> (HALF_W - n));
    endfunction

    function automatic logic [31:0] round_const(input logic [4:0] r);
        return {3'b000, r, 3'b111, ~r, 8'h5A ^ {3'b000, r}, 8'hC3};
    endfunction

    // Quadratic 4-bit S-box in two-share form: the only share interaction is inside the AND cross-terms.
    function automatic logic [HALF_W-1:0] sbox_share(input logic [HALF_W-1:0] xs,
                                                     input logic [HALF_W-1:0] xo,
                                                     input logic add_const);
        logic [HALF_W-1:0] y;
        logic [3:0] a;
        logic [3:0] b;
        logic q;
        y = '0;
        for (int i = 0; i < NIB; i++) begin
            a = xs[4*i +: 4];
            b = xo[4*i +: 4];
            q = (a[1] & a[2]) ^ (a[1] & b[2]);
            y[4*i +: 4] = {a[0] ^ q, a[3] ^ q ^ a[0], a[2], a[1] ^ a[3]} ^ (add_const ? 4'b0101 : 4'b0000);
        end
        return y;
    endfunction

    function automatic logic [HALF_W-1:0] lin_mix(input logic [HALF_W-1:0] s);
        return s ^ rotl(s, 16);
    endfunction

    state_t state, state_nxt;
    logic [4:0] round_cnt;
    logic done_nxt;
    logic [HALF_W-1:0] k0_cur, k0_prv, k1_cur, k1_prv;
    logic [HALF_W-1:0] sb0_p [SBOX_LAT];
    logic [HALF_W-1:0] sb1_p [SBOX_LAT];
    logic [SBOX_LAT-1:0] vld_p;
    logic issue, commit;
    logic [HALF_W-1:0] pk0, pk1, sb0_in, sb1_in, nxt0_cur, nxt1_cur;
    logic [HALF_W-1:0] rm_cur, rm_prv;

    assign ready  = (state == IDLE);
    assign rk_idx = round_cnt;
    assign issue  = (state == STEP) && (vld_p == '0);
    assign commit = vld_p[SBOX_LAT-1];

    if (KEY_W == 128) begin : g_out128
        assign rk_out0 = {k0_cur, k0_prv};
        assign rk_out1 = {k1_cur, k1_prv};
    end else begin : g_out256
        assign rk_out0 = k0_cur;
        assign rk_out1 = k1_cur;
    end

`ifdef KEY_SCHED_REMASK_EN
    assign rm_cur = rand_in[KEY_W-1 -: HALF_W];
    assign rm_prv = rand_in[HALF_W-1:0];
`else
    assign rm_cur = '0;
    assign rm_prv = '0;
`endif

    // Round constant tracks round_cnt so every new schedule restarts at RC(1).
    assign pk0    = rotl(k0_cur, 8) ^ {round_const(round_cnt + 5'd1), {(HALF_W-32){1'b0}}};
    assign pk1    = rotl(k1_cur, 8);
    assign sb0_in = sbox_share(pk0, pk1, 1'b1);
    assign sb1_in = sbox_share(pk1, pk0, 1'b0);
    assign nxt0_cur = lin_mix(sb0_p[SBOX_LAT-1]) ^ k0_prv;
    assign nxt1_cur = lin_mix(sb1_p[SBOX_LAT-1]) ^ k1_prv;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = PRESENT;
            PRESENT: if (rk_ready) begin
                if (round_cnt == LAST_IDX) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = STEP;
                end
            end
            STEP:    if (commit) state_nxt = PRESENT;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
            round_cnt <= '0;
            vld_p     <= '0;
        end else begin
            state    <= state_nxt;
            rk_valid <= (state_nxt == PRESENT);
            done     <= done_nxt;
            vld_p    <= abort ? '0 : ((vld_p << 1) | SBOX_LAT'(issue));
            if (abort || state == LOAD)
                round_cnt <= '0;
            else if (commit)
                round_cnt <= round_cnt + 5'd1;
        end
    end

    // S-box stage boundary: SBOX_LAT registers per share between PK layer and linear mix.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || abort) begin
            for (int i = 0; i < SBOX_LAT; i++) begin
                sb0_p[i] <= '0;
                sb1_p[i] <= '0;
            end
        end else if (state == STEP) begin
            sb0_p[0] <= sb0_in;
            sb1_p[0] <= sb1_in;
            for (int i = 1; i < SBOX_LAT; i++) begin
                sb0_p[i] <= sb0_p[i-1];
                sb1_p[i] <= sb1_p[i-1];
            end
        end
    end

    // Key state boundary: current half is mixed and XORed with previous half; old current becomes previous.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k0_cur <= '0;
            k0_prv <= '0;
            k1_cur <= '0;
            k1_prv <= '0;
        end else if (abort) begin
            k0_cur <= '0;
            k0_prv <= '0;
            k1_cur <= '0;
            k1_prv <= '0;
        end else if (ready && start) begin
            k0_cur <= key_in0[KEY_W-1 -: HALF_W];
            k0_prv <= key_in0[HALF_W-1:0];
            k1_cur <= key_in1[KEY_W-1 -: HALF_W];
            k1_prv <= key_in1[HALF_W-1:0];
        end else if (commit) begin
            k0_cur <= nxt0_cur ^ rm_cur;
            k0_prv <= k0_cur ^ rm_prv;
            k1_cur <= nxt1_cur ^ rm_cur;
            k1_prv <= k1_cur ^ rm_prv;
        end
    end

endmodule

// File: tb/tb_shared_key_schedule_engine.sv
// Randomized bench for shared_key_schedule_engine: 128-bit and 256-bit instances against an unmasked reference schedule.
module tb_shared_key_schedule_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, abort, rk_ready, start_a, start_b, wide;
    logic [127:0] key_a0, key_a1;
    logic [255:0] key_b0, key_b1;
    logic [127:0] a_rk0, a_rk1, b_rk0, b_rk1;
    logic [4:0] a_idx, b_idx;
    logic a_ready, b_ready, a_valid, b_valid, a_done, b_done;
    logic [127:0] gold [25];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    logic [3:0] sbox_tbl [16] = '{4'h5, 4'h9, 4'h4, 4'h8, 4'h7, 4'hB, 4'hA, 4'h6,
                                  4'h0, 4'hC, 4'h1, 4'hD, 4'h2, 4'hE, 4'hF, 4'h3};

    always @(posedge clk) cyc <= cyc + 1;

`ifdef KEY_SCHED_REMASK_EN
    logic [127:0] rand_a;
    logic [255:0] rand_b;
    initial begin
        rand_a = '0;
        rand_b = '0;
        forever begin
            @(negedge clk);
            rand_a = {$urandom, $urandom, $urandom, $urandom};
            rand_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
    end
`endif

    shared_key_schedule_engine #(.KEY_W(128), .NROUNDS(16), .SBOX_LAT(1)) u_k128 (
        .clk(clk), .rstn(rstn), .start(start_a), .ready(a_ready), .abort(abort),
        .key_in0(key_a0), .key_in1(key_a1),
`ifdef KEY_SCHED_REMASK_EN
        .rand_in(rand_a),
`endif
        .rk_out0(a_rk0), .rk_out1(a_rk1), .rk_idx(a_idx), .rk_valid(a_valid),
        .rk_ready(rk_ready), .done(a_done)
    );

    shared_key_schedule_engine #(.KEY_W(256), .NROUNDS(24), .SBOX_LAT(2)) u_k256 (
        .clk(clk), .rstn(rstn), .start(start_b), .ready(b_ready), .abort(abort),
        .key_in0(key_b0), .key_in1(key_b1),
`ifdef KEY_SCHED_REMASK_EN
        .rand_in(rand_b),
`endif
        .rk_out0(b_rk0), .rk_out1(b_rk1), .rk_idx(b_idx), .rk_valid(b_valid),
        .rk_ready(rk_ready), .done(b_done)
    );

    logic [127:0] o_rk0, o_rk1;
    logic [4:0] o_idx;
    logic o_ready, o_valid, o_done;
    assign o_rk0   = wide ? b_rk0 : a_rk0;
    assign o_rk1   = wide ? b_rk1 : a_rk1;
    assign o_idx   = wide ? b_idx : a_idx;
    assign o_ready = wide ? b_ready : a_ready;
    assign o_valid = wide ? b_valid : a_valid;
    assign o_done  = wide ? b_done : a_done;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rotl_ref(input logic [255:0] x, input int n, input int hw);
        logic [255:0] y = '0;
        for (int j = 0; j < hw; j++) y[(j + n) % hw] = x[j];
        return y;
    endfunction

    function automatic logic [31:0] rc_ref(input int r);
        logic [7:0] r8 = 8'(r);
        return {r8, ~r8, r8 ^ 8'h5A, 8'hC3};
    endfunction

    // One unmasked round on a key held in the low 2*hw bits.
    function automatic logic [255:0] ref_round(input logic [255:0] k, input int hw, input int r);
        logic [255:0] mask, h, l, p, s, t;
        mask = (256'd1 << hw) - 256'd1;
        h = (k >> hw) & mask;
        l = k & mask;
        p = rotl_ref(h, 8, hw) ^ ({224'd0, rc_ref(r)} << (hw - 32));
        s = '0;
        for (int i = 0; i < hw / 4; i++) s[4*i +: 4] = sbox_tbl[p[4*i +: 4]];
        t = s ^ rotl_ref(s, 16, hw);
        return ((t ^ l) << hw) | h;
    endfunction

    task automatic run_sched(input bit w, input bit reuse, input int stall_idx,
                             input int abort_idx, input int rst_idx);
        int nr, sp, t_start, hs, wt, exp_arr;
        logic [255:0] kk;
        logic [127:0] snap0, snap1;
        logic [4:0] snap_idx;
        nr = w ? 24 : 16;
        sp = w ? 4 : 3;
        wide = w;
        if (!reuse) begin
            key_a0 = rnd128();
            key_a1 = rnd128();
            key_b0 = {rnd128(), rnd128()};
            key_b1 = {rnd128(), rnd128()};
        end
        kk = w ? (key_b0 ^ key_b1) : {128'd0, key_a0 ^ key_a1};
        for (int n = 0; n <= nr; n++) begin
            gold[n] = w ? kk[255:128] : kk[127:0];
            kk = ref_round(kk, w ? 128 : 64, n + 1);
        end
        @(negedge clk);
        chk("idle_ready", o_ready, 1);
        if (w) start_b = 1'b1; else start_a = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk("load_valid", o_valid, 0);
        chk("load_ready", o_ready, 0);
        @(negedge clk);
        hs = 0;
        for (int n = 0; n <= nr; n++) begin
            wt = 0;
            while (!o_valid && wt < 16) begin
                @(negedge clk);
                wt++;
            end
            chk($sformatf("rk%0d_valid", n), o_valid, 1);
            if (!o_valid) return;
            exp_arr = (n == 0) ? t_start + 2 : hs + sp;
            chk($sformatf("rk%0d_time", n), cyc, exp_arr);
            chk($sformatf("rk%0d_idx", n), o_idx, n);
            chk($sformatf("rk%0d_key", n), o_rk0 ^ o_rk1, gold[n]);
            chk($sformatf("rk%0d_nodone", n), o_done, 0);
            if (n == rst_idx) begin
                rk_ready = 1'b0;
                #3 rstn = 1'b0;
                #1;
                chk("rst_valid", o_valid, 0);
                chk("rst_ready", o_ready, 1);
                chk("rst_done", o_done, 0);
                chk("rst_idx", o_idx, 0);
                chk("rst_out0", o_rk0, 0);
                chk("rst_out1", o_rk1, 0);
                if (w) start_b = 1'b1; else start_a = 1'b1;
                @(negedge clk);
                chk("rst_start_ignored", o_ready, 1);
                chk("rst_start_valid", o_valid, 0);
                start_a = 1'b0;
                start_b = 1'b0;
                rstn = 1'b1;
                rk_ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("rst_no_partial", o_valid, 0);
                end
                return;
            end
            if (n == stall_idx) begin
                snap0 = o_rk0;
                snap1 = o_rk1;
                snap_idx = o_idx;
                rk_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", o_valid, 1);
                    chk("hold_idx", o_idx, snap_idx);
                    chk("hold_out0", o_rk0, snap0);
                    chk("hold_out1", o_rk1, snap1);
                end
                rk_ready = 1'b1;
            end
            hs = cyc;
            @(negedge clk);
            if (n + 1 == abort_idx) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_valid", o_valid, 0);
                chk("abort_ready", o_ready, 1);
                repeat (4) begin
                    chk("abort_no_done", o_done, 0);
                    @(negedge clk);
                end
                return;
            end
        end
        chk("done_pulse", o_done, 1);
        chk("done_valid", o_valid, 0);
        @(negedge clk);
        chk("done_clear", o_done, 0);
        chk("done_ready", o_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        abort = 1'b0;
        rk_ready = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        wide = 1'b0;
        key_a0 = '0;
        key_a1 = '0;
        key_b0 = '0;
        key_b1 = '0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            wide = w[0];
            #1;
            chk("reset_ready", o_ready, 1);
            chk("reset_valid", o_valid, 0);
            chk("reset_done", o_done, 0);
            chk("reset_idx", o_idx, 0);
            chk("reset_out0", o_rk0, 0);
        end
        @(negedge clk);
        rstn = 1'b1;

        run_sched(1'b0, 1'b0, -1, -1, -1);
        run_sched(1'b0, 1'b0, 3, -1, -1);
        run_sched(1'b0, 1'b0, -1, 7, -1);
        run_sched(1'b0, 1'b1, -1, -1, -1);
        run_sched(1'b0, 1'b0, -1, -1, 9);
        run_sched(1'b0, 1'b0, -1, -1, -1);
        run_sched(1'b1, 1'b0, -1, -1, -1);
        run_sched(1'b1, 1'b0, 5, -1, -1);

        // start coincident with abort while idle must not launch a schedule
        wide = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort = 1'b0;
        chk("start_abort_ready", o_ready, 1);
        @(negedge clk);
        chk("start_abort_valid", o_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
